// File: rtl/fifo_pkg.sv
// Width helpers and parameter legality rules shared by the virtual-channel FIFO.
// The top module turns params_ok() into an elaboration-time error.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    function automatic int vcw_of(input int num_vc);
        return clog2(num_vc);
    endfunction

    // One extra pointer bit distinguishes a full buffer from an empty one.
    function automatic int cw_of(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int num_vc, input int afull_th);
        return (width >= 32'sd1) && (depth >= 32'sd2) && is_pow2(depth) &&
               (num_vc >= 32'sd2) && (afull_th >= 32'sd1) && (afull_th <= depth);
    endfunction

endpackage

// File: rtl/vc_fifo_ptr.sv
// Pointer pair and status-flag decode for a single virtual channel.
// Flags depend only on the registered pointers, never on this cycle's requests.
module vc_fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 1,
    localparam int CW      = cw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_wr,
    input  logic          inc_rd,
    output logic [CW-2:0] wr_addr,
    output logic [CW-2:0] rd_addr,
    output logic          empty,
    output logic          full,
    output logic          afull
);

    localparam logic [CW-1:0] PTR_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);

    logic [CW-1:0] wr_ptr_r;
    logic [CW-1:0] rd_ptr_r;
    logic [CW-1:0] occ_s;

    // Pointer registers; natural modulo-2^CW wrap, no special case needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {CW{1'b0}};
            rd_ptr_r <= {CW{1'b0}};
        end else begin
            if (inc_wr) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (inc_rd) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    assign occ_s   = wr_ptr_r - rd_ptr_r;
    assign empty   = (occ_s == {CW{1'b0}});
    assign full    = (occ_s == DEPTH_C);
    assign afull   = (occ_s >= AFULL_C);
    assign wr_addr = wr_ptr_r[CW-2:0];
    assign rd_addr = rd_ptr_r[CW-2:0];

endmodule

// File: rtl/vc_fifo.sv
// Multi-virtual-channel FIFO: NUM_VC independent circular buffers sharing one
// flat storage array, with a registered one-cycle-latency read port.
module vc_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_VC   = 4,
    parameter int AFULL_TH = DEPTH - 1,
    localparam int VCW     = vcw_of(NUM_VC),
    localparam int CW      = cw_of(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_i,
    input  logic [VCW-1:0]    wr_vc_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              read_i,
    input  logic [VCW-1:0]    rd_vc_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              valid_o,
    output logic [NUM_VC-1:0] empty_o,
    output logic [NUM_VC-1:0] full_o,
    output logic [NUM_VC-1:0] afull_o,
    output logic              ovf_o
);

    localparam int AW = VCW + CW - 1;
    localparam logic [NUM_VC-1:0] VC_ONE = {{(NUM_VC-1){1'b0}}, 1'b1};

    if (!params_ok(WIDTH, DEPTH, NUM_VC, AFULL_TH)) begin : g_bad_params
        $error("vc_fifo: illegal parameter set");
    end

    logic [CW-2:0]      wr_idx_s [NUM_VC];
    logic [CW-2:0]      rd_idx_s [NUM_VC];
    logic [NUM_VC-1:0]  wr_inc_s;
    logic [NUM_VC-1:0]  rd_inc_s;
    logic               rd_ok_s;
    logic               wr_ok_s;
    logic [AW-1:0]      wr_addr_s;
    logic [AW-1:0]      rd_addr_s;
    logic [WIDTH-1:0]   mem_r [NUM_VC*DEPTH];
    logic [WIDTH-1:0]   data_r;
    logic               valid_r;
    logic               ovf_r;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_ptr #(
            .DEPTH    (DEPTH),
            .AFULL_TH (AFULL_TH)
        ) u_ptr (
            .clk     (clk_i),
            .rst_n   (rst_i),
            .inc_wr  (wr_inc_s[v]),
            .inc_rd  (rd_inc_s[v]),
            .wr_addr (wr_idx_s[v]),
            .rd_addr (rd_idx_s[v]),
            .empty   (empty_o[v]),
            .full    (full_o[v]),
            .afull   (afull_o[v])
        );
    end

    // Accept decode: a full VC still takes a write when the same VC is read this cycle.
    always_comb begin
        rd_ok_s   = read_i & ~empty_o[rd_vc_i];
        wr_ok_s   = write_i & (~full_o[wr_vc_i] | (rd_ok_s & (rd_vc_i == wr_vc_i)));
        rd_addr_s = {rd_vc_i, rd_idx_s[rd_vc_i]};
        wr_addr_s = {wr_vc_i, wr_idx_s[wr_vc_i]};
        if (rd_ok_s) begin
            rd_inc_s = VC_ONE << rd_vc_i;
        end else begin
            rd_inc_s = {NUM_VC{1'b0}};
        end
        if (wr_ok_s) begin
            wr_inc_s = VC_ONE << wr_vc_i;
        end else begin
            wr_inc_s = {NUM_VC{1'b0}};
        end
    end

    // Storage is deliberately not reset; reads on a full VC see the old head word.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_r[wr_addr_s] <= data_i;
        end
    end

    // Registered read port: valid pulses for one cycle per accepted read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                data_r <= mem_r[rd_addr_s];
            end else begin
                data_r <= data_r;
            end
        end
    end

    // Sticky overflow, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_r <= 1'b0;
        end else if (write_i && !wr_ok_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign ovf_o   = ovf_r;

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32: data word width in bits.
REQ-002 The block SHALL have a parameter DEPTH, default 8: entries per virtual channel; power of two, at least 2.
REQ-003 The block SHALL have a parameter NUM_VC, default 4: number of virtual channels; at least 2.
REQ-004 The block SHALL have a parameter AFULL_TH, default DEPTH-1: per-VC occupancy at which almost-full asserts; range 1 to DEPTH.
REQ-005 Derived widths SHALL be VCW = clog2(NUM_VC) and CW = clog2(DEPTH)+1.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port write_i, input, 1 bit: write request.
REQ-009 The block SHALL have port wr_vc_i, input, VCW bits: target VC of the write.
REQ-010 The block SHALL have port data_i, input, WIDTH bits: write data.
REQ-011 The block SHALL have port read_i, input, 1 bit: read request.
REQ-012 The block SHALL have port rd_vc_i, input, VCW bits: source VC of the read.
REQ-013 The block SHALL have port data_o, output, WIDTH bits: registered read data.
REQ-014 The block SHALL have port valid_o, output, 1 bit: data_o was updated by the previous cycle's accepted read.
REQ-015 The block SHALL have port empty_o, output, NUM_VC bits: per-VC empty flag.
REQ-016 The block SHALL have port full_o, output, NUM_VC bits: per-VC full flag.
REQ-017 The block SHALL have port afull_o, output, NUM_VC bits: per-VC occupancy is at least AFULL_TH.
REQ-018 The block SHALL have port ovf_o, output, 1 bit: sticky flag, set by a dropped write.

Function
REQ-019 Each VC SHALL be an independent circular buffer of DEPTH entries with CW-bit read and write pointers; the MSB is the wrap bit.
REQ-020 A write SHALL be accepted when write_i=1 and either full_o[wr_vc_i]=0, or a read of the same VC is accepted in the same cycle.
REQ-021 A write that is not accepted SHALL be dropped, set ovf_o, and leave buffer state unchanged.
REQ-022 A read SHALL be accepted when read_i=1 and empty_o[rd_vc_i]=0 at the start of the cycle; there SHALL be no write-to-read bypass.
REQ-023 An accepted read SHALL load the head word into data_o at that clock edge and assert valid_o for exactly one cycle; read latency is 1.
REQ-024 A rejected or absent read SHALL hold data_o and drive valid_o=0.
REQ-025 Simultaneous accepted read and write on the same VC SHALL leave that VC's occupancy unchanged; on different VCs each SHALL update independently.
REQ-026 Occupancy SHALL equal wr_ptr - rd_ptr, modulo 2^CW.
REQ-027 empty_o[v] SHALL be high when occupancy is 0; full_o[v] SHALL be high when occupancy equals DEPTH; afull_o[v] SHALL be high when occupancy is at least AFULL_TH.
REQ-028 All flags SHALL be decoded combinationally from registered pointers only, never from current-cycle requests.
REQ-029 Pointer increment SHALL wrap from 2^CW-1 to 0 with no special case.
REQ-030 ovf_o SHALL clear only on reset.

Reset
REQ-031 On rst_i low, all pointers SHALL clear immediately: empty_o all ones, full_o and afull_o all zeros, valid_o=0, ovf_o=0, data_o all zeros.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Requests during reset SHALL be ignored; reset asserted mid-operation SHALL discard all queued words in every VC.
REQ-034 Release of rst_i SHALL take effect at the next clk_i edge with no extra wait cycles.

Structure
REQ-035 Package fifo_pkg SHALL hold the clog2-based width helpers and the parameter legality checks, enforced as elaboration-time assertions.
REQ-036 Sub-module vc_fifo_ptr SHALL implement one VC's pointer pair and flag decode, instantiated NUM_VC times by a generate loop.
REQ-037 Storage SHALL be one flat array of NUM_VC*DEPTH words, addressed by {vc, ptr[CW-2:0]}.

Verification
REQ-038 Reset release, then 8 writes of 0x10-0x17 to VC2 -> full_o=4'b0100 and afull_o[2]=1 after the 7th write.
REQ-039 9th write to full VC2 -> dropped, ovf_o=1; then 8 reads of VC2 -> data_o 0x10-0x17 in order, each with a one-cycle valid_o pulse.
REQ-040 VC1 full, read and write VC1 in the same cycle with data_i=0xAA -> full_o[1] stays 1, ovf_o stays 0, 0xAA is dequeued last.
REQ-041 Read of empty VC0 together with a write of 0x55 to VC0 -> valid_o=0 that cycle; next-cycle read returns 0x55.
REQ-042 Interleaved writes to VC0 and VC3 (12 words each, with reads, so pointers wrap) -> per-VC order preserved and no cross-VC leakage.
REQ-043 rst_i low mid-burst with VC0 holding 5 words -> empty_o=4'b1111 asynchronously; a read after release -> valid_o=0.
